// File: rtl/i2c_mem_pkg.sv
// Shared types and constants for the I2C memory responder.
package i2c_mem_pkg;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ADDRWIDTH = 7;
  localparam int BYTE_BITS     = 8;
  localparam int CNT_W         = $clog2(BYTE_BITS + 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_FETCH,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for SCL/SDA plus edge and START/STOP condition pulses.
// Lines reset to the idle-high level so leaving reset never fakes a START.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Shift the pad values through the synchroniser chain, keep last-stage history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign sda      = w_sda;
  assign scl_rise = w_scl & ~r_scl_prev;
  assign scl_fall = ~w_scl & r_scl_prev;
  // SDA may only move under a steady-high SCL for a bus condition.
  assign start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
endmodule

// File: rtl/i2c_mem_slave.sv
// I2C responder bridging bus transfers onto single-cycle memory strobes.
// First byte is {addr, rw}; then one data byte written or read.
// Optional feature macro: I2C_SLV_AUTOINC_EN (multi-byte bursts, addr+1 per byte).
module i2c_mem_slave
  import i2c_mem_pkg::*;
#(
  parameter int DATAWIDTH   = DEF_DATAWIDTH,
  parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0] wdata,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic                 busy
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTE_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_BITS - 1);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda      (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  state_t               r_state,   w_state;
  logic [CNT_W-1:0]     r_bitcnt,  w_bitcnt;
  logic [DATAWIDTH-1:0] r_shift,   w_shift;
  logic                 r_rw,      w_rw;
  logic [ADDRWIDTH-1:0] r_addr,    w_addr;
  logic [DATAWIDTH-1:0] r_wdata,   w_wdata;
  logic                 r_wr_en,   w_wr_en;
  logic                 r_rd_en,   w_rd_en;
  logic                 r_sda_oe,  w_sda_oe;
  logic                 r_busy,    w_busy;
  logic                 r_wr_pend, w_wr_pend;
  logic [1:0]           r_fph,     w_fph;

  // Register all FSM state and outputs; reset releases SDA on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_pend <= 1'b0;
      r_fph     <= '0;
    end else begin
      r_state   <= w_state;
      r_bitcnt  <= w_bitcnt;
      r_shift   <= w_shift;
      r_rw      <= w_rw;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_sda_oe  <= w_sda_oe;
      r_busy    <= w_busy;
      r_wr_pend <= w_wr_pend;
      r_fph     <= w_fph;
    end
  end

  // Next-state logic; bus conditions override byte handling, STOP first.
  always_comb begin
    w_state   = r_state;
    w_bitcnt  = r_bitcnt;
    w_shift   = r_shift;
    w_rw      = r_rw;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_sda_oe  = r_sda_oe;
    w_busy    = r_busy;
    w_wr_pend = 1'b0;
    w_fph     = r_fph;
    if (w_stop) begin
      w_state  = IDLE;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
      w_bitcnt = '0;
    end else if (w_start) begin
      w_state  = ADDR;
      w_sda_oe = 1'b0;
      w_busy   = 1'b1;
      w_bitcnt = '0;
    end else begin
      // Complete byte captured last clk: present it with the strobe.
      if (r_wr_pend) begin
        w_wr_en = 1'b1;
        w_wdata = r_shift;
      end
      unique case (r_state)
        IDLE: ;
        ADDR: begin
          if (w_scl_rise && r_bitcnt < CNT_FULL) begin
            w_shift  = {r_shift[DATAWIDTH-2:0], w_sda};
            w_bitcnt = r_bitcnt + 1'b1;
          end else if (w_scl_fall && r_bitcnt == CNT_FULL) begin
            w_state  = ADDR_ACK;
            w_sda_oe = 1'b1;
            w_addr   = r_shift[ADDRWIDTH:1];
            w_rw     = r_shift[0];
            w_bitcnt = '0;
          end
        end
        ADDR_ACK: begin
          // Reads fetch while the master is still sampling our ACK.
          if (r_rw && w_scl_rise) begin
            w_state = RD_FETCH;
            w_fph   = '0;
          end else if (!r_rw && w_scl_fall) begin
            w_state  = WR_DATA;
            w_sda_oe = 1'b0;
          end
        end
        WR_DATA: begin
          if (w_scl_rise && r_bitcnt < CNT_FULL) begin
            w_shift  = {r_shift[DATAWIDTH-2:0], w_sda};
            w_bitcnt = r_bitcnt + 1'b1;
            if (r_bitcnt == CNT_LAST) w_wr_pend = 1'b1;
          end else if (w_scl_fall && r_bitcnt == CNT_FULL) begin
            w_state  = WR_ACK;
            w_sda_oe = 1'b1;
            w_bitcnt = '0;
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
`ifdef I2C_SLV_AUTOINC_EN
            w_state  = WR_DATA;
            w_addr   = r_addr + ADDRWIDTH'(1);
`else
            w_state  = WAIT_STOP;
`endif
          end
        end
        RD_FETCH: begin
          unique case (r_fph)
            2'd0: begin
              w_rd_en = 1'b1;
              w_fph   = 2'd1;
            end
            2'd1: w_fph = 2'd2;
            default: begin
              w_shift  = rd_data;
              w_bitcnt = '0;
              w_state  = RD_DATA;
            end
          endcase
        end
        RD_DATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt < CNT_FULL) begin
              w_sda_oe = ~r_shift[DATAWIDTH-1];
              w_shift  = {r_shift[DATAWIDTH-2:0], 1'b0};
              w_bitcnt = r_bitcnt + 1'b1;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            w_state = WAIT_STOP;
`ifdef I2C_SLV_AUTOINC_EN
            if (!w_sda) begin
              w_state = RD_FETCH;
              w_fph   = '0;
              w_addr  = r_addr + ADDRWIDTH'(1);
            end
`endif
          end
        end
        WAIT_STOP: w_sda_oe = 1'b0;
        default:   w_state  = IDLE;
      endcase
    end
  end

  assign sda_oe = r_sda_oe;
  assign wr_en  = r_wr_en;
  assign rd_en  = r_rd_en;
  assign addr   = r_addr;
  assign wdata  = r_wdata;
  assign busy   = r_busy;
endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench for i2c_mem_slave: bit-banged master, small read memory model.
module tb_i2c_mem_slave;
  import i2c_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rd_data;
  logic       sda_line;

  logic [7:0] rd_mem [128];

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [6:0] wr_a [16];
  logic [7:0] wr_d [16];
  logic [6:0] rd_a_last;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (m_scl),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always @(posedge clk) if (rd_en) rd_data <= rd_mem[addr];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a[wr_cnt % 16] <= addr;
      wr_d[wr_cnt % 16] <= wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_en) begin
      rd_a_last <= addr;
      rd_cnt    <= rd_cnt + 1;
    end
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic send_bit(input logic b, output logic got);
    m_sda = b; q();
    m_scl = 1'b1; q();
    got = sda_line; q();
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) send_bit(b[i], g);
    send_bit(1'b1, g);
    ack = ~g;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic g;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, g);
      d = {d[6:0], g};
    end
    send_bit(~mack, g);
  endtask

  initial begin
    logic       ack;
    logic       g;
    logic [7:0] d;
    int         w0, r0;

    rd_mem[7'h2A] = 8'h96;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_wr_en",  32'(wr_en),  0);
    chk("rst_rd_en",  32'(rd_en),  0);
    chk("rst_addr",   32'(addr),   0);
    chk("rst_wdata",  32'(wdata),  0);
    chk("rst_busy",   32'(busy),   0);
    rst = 1'b0;
    q();

    // 1: single byte write 0xC3 to 0x2A
    w0 = wr_cnt;
    bus_start();
    chk("c1_busy_on", 32'(busy), 1);
    send_byte(8'h54, ack); chk("c1_ack_addr", 32'(ack), 1);
    send_byte(8'hC3, ack); chk("c1_ack_data", 32'(ack), 1);
    bus_stop(); q();
    chk("c1_wr_count", 32'(wr_cnt - w0), 1);
    chk("c1_wr_addr",  32'(wr_a[w0 % 16]), 32'h2A);
    chk("c1_wr_data",  32'(wr_d[w0 % 16]), 32'hC3);
    chk("c1_busy_off", 32'(busy), 0);

    // 2: single byte read of 0x2A, master NACK
    r0 = rd_cnt; w0 = wr_cnt;
    bus_start();
    send_byte(8'h55, ack); chk("c2_ack_addr", 32'(ack), 1);
    recv_byte(1'b0, d);
    chk("c2_rd_data",  32'(d), 32'h96);
    bus_stop(); q();
    chk("c2_rd_count", 32'(rd_cnt - r0), 1);
    chk("c2_rd_addr",  32'(rd_a_last), 32'h2A);
    chk("c2_wr_count", 32'(wr_cnt - w0), 0);
    chk("c2_busy_off", 32'(busy), 0);
    chk("c2_sda_oe",   32'(sda_oe), 0);

    // 3: two-byte write starting at 0x7F
    w0 = wr_cnt;
    bus_start();
    send_byte(8'hFE, ack); chk("c3_ack_addr", 32'(ack), 1);
    send_byte(8'h11, ack); chk("c3_ack_b0",   32'(ack), 1);
    send_byte(8'h22, ack);
`ifdef I2C_SLV_AUTOINC_EN
    chk("c3_ack_b1", 32'(ack), 1);
`else
    chk("c3_nack_b1", 32'(ack), 0);
`endif
    bus_stop(); q();
    chk("c3_wr0_addr", 32'(wr_a[w0 % 16]), 32'h7F);
    chk("c3_wr0_data", 32'(wr_d[w0 % 16]), 32'h11);
`ifdef I2C_SLV_AUTOINC_EN
    chk("c3_wr_count", 32'(wr_cnt - w0), 2);
    chk("c3_wr1_addr", 32'(wr_a[(w0 + 1) % 16]), 32'h00);
    chk("c3_wr1_data", 32'(wr_d[(w0 + 1) % 16]), 32'h22);
`else
    chk("c3_wr_count", 32'(wr_cnt - w0), 1);
`endif

    // 4: STOP after 5 data bits discards the partial byte
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h54, ack); chk("c4_ack_addr", 32'(ack), 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, g);
    bus_stop(); q();
    chk("c4_wr_count", 32'(wr_cnt - w0), 0);
    chk("c4_state",    32'(dut.r_state), 32'(IDLE));
    chk("c4_sda_oe",   32'(sda_oe), 0);
    chk("c4_busy",     32'(busy), 0);

    // 5: repeated START after write address turns into a read
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    send_byte(8'h54, ack); chk("c5_ack_waddr", 32'(ack), 1);
    bus_rstart();
    chk("c5_state_addr", 32'(dut.r_state), 32'(ADDR));
    send_byte(8'h55, ack); chk("c5_ack_raddr", 32'(ack), 1);
    recv_byte(1'b0, d);
    chk("c5_rd_data", 32'(d), 32'h96);
    bus_stop(); q();
    chk("c5_wr_count", 32'(wr_cnt - w0), 0);
    chk("c5_rd_count", 32'(rd_cnt - r0), 1);
    chk("c5_rd_addr",  32'(rd_a_last), 32'h2A);

    // 6: reset while driving a read 0 bit, then a clean write
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    send_byte(8'h55, ack); chk("c6_ack_addr", 32'(ack), 1);
    send_bit(1'b1, g);
    chk("c6_bit7", 32'(g), 1);
    m_sda = 1'b1; q();
    chk("c6_pre_oe", 32'(sda_oe), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("c6_rst_oe",   32'(sda_oe), 0);
    chk("c6_rst_busy", 32'(busy), 0);
    chk("c6_rst_wr",   32'(wr_en), 0);
    chk("c6_rst_rd",   32'(rd_en), 0);
    rst = 1'b0;
    q();
    m_scl = 1'b1; q(); q();
    chk("c6_rd_count", 32'(rd_cnt - r0), 1);
    bus_start();
    send_byte(8'h54, ack); chk("c6_ack_waddr", 32'(ack), 1);
    send_byte(8'h5A, ack); chk("c6_ack_data",  32'(ack), 1);
    bus_stop(); q();
    chk("c6_wr_count", 32'(wr_cnt - w0), 1);
    chk("c6_wr_addr",  32'(wr_a[w0 % 16]), 32'h2A);
    chk("c6_wr_data",  32'(wr_d[w0 % 16]), 32'h5A);

    chk("excl_wr_rd", 32'(both_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
